alu_uart_scheduler: RTL
=======================

Name: alu_uart_scheduler

Overview:
Shares the single ALU and UART-TX resource pair between two requesters: requester 0 is the pin-level operand/opcode input, requester 1 is the on-chip command source. The block arbitrates round-robin, issues one operation to the ALU, captures the 16-bit result, and optionally streams it over UART as two bytes, high byte first. It then returns the result to the winning requester. It sits between the top-level input logic and the ALU/UART datapath, replacing direct FSM-to-ALU wiring.

Parameters:
ALU_LAT, 1, cycles from alu_start to valid alu_result; legal range 1..7.

Ports:
clock  in  1  system clock; all logic is on the rising edge.
reset  in  1  synchronous, active-high reset.
req0_valid  in  1  requester 0 has an operation pending.
req0_ready  out  1  requester 0 operation accepted this cycle (when valid is also high).
req0_a / req0_b  in  8 each  operands for requester 0.
req0_op  in  3  opcode for requester 0.
req1_valid, req1_ready, req1_a, req1_b, req1_op  same widths and meanings as requester 0, for requester 1.
tx_enable  in  1  1 = send the result over UART; 0 = skip the UART phase.
alu_a / alu_b  out  8 each  registered operands driven to the ALU.
alu_op  out  3  registered opcode driven to the ALU.
alu_start  out  1  one-cycle issue pulse to the ALU.
alu_result  in  16  ALU result, valid ALU_LAT cycles after alu_start.
uart_data  out  8  byte to transmit.
uart_start  out  1  one-cycle transmit request.
uart_busy  in  1  UART is shifting; it rises the cycle after uart_start.
resp_valid  out  1  one-cycle completion pulse.
resp_id  out  1  index of the requester that owns the response.
resp_result  out  16  captured ALU result.
busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (synchronous, wins over everything): state goes to IDLE and last_grant is set to 1, so requester 0 wins first.
  - These outputs are 0 after reset: alu_a, alu_b, alu_op, alu_start, uart_data, uart_start, resp_valid, resp_id, resp_result, busy, req*_ready.
  - Reset in any state abandons the operation; no resp_valid is produced.
- States: IDLE, ISSUE, WAIT_ALU, TX_HI, TX_HI_WAIT, TX_LO, TX_LO_WAIT, DONE.
- IDLE:
  - grant is computed combinationally.
  - If only one requester is valid, it wins.
  - If both are valid, the requester other than last_grant wins.
  - reqN_ready = (state==IDLE) & (grant==N); ready is never asserted for a non-valid requester.
  - On a handshake: latch a, b, op and id into alu_*/resp_id, update last_grant, and go to ISSUE.
- ISSUE: alu_start=1 for exactly one cycle, then go to WAIT_ALU.
- WAIT_ALU:
  - Stays for ALU_LAT cycles using a 3-bit down-counter.
  - On the last cycle, alu_result is captured into resp_result.
  - Next state is TX_HI if tx_enable was 1 at acceptance time (latched); otherwise DONE.
- TX_HI:
  - Waits until uart_busy==0, then drives uart_data=resp_result[15:8] and uart_start=1 for one cycle.
  - Then goes to TX_HI_WAIT.
- TX_HI_WAIT:
  - The first cycle is ignored (the UART raises busy a cycle late).
  - Afterwards the block stays until uart_busy==0, then goes to TX_LO.
- TX_LO / TX_LO_WAIT: identical to the high-byte states, using resp_result[7:0]. TX_LO_WAIT exits to DONE.
- DONE: resp_valid=1 for one cycle, resp_result and resp_id are held, then go to IDLE.
  - resp_result holds its value until the next capture.
- Operands and opcode are 8/8/3 bits, passed through unchanged; no arithmetic is done in this block.
- Requests are not accepted while busy; valid held high on a requester simply waits.
- tx_enable changing mid-operation has no effect; the latched copy is used.
- Latency with tx_enable=0 and ALU_LAT=L:
  - Handshake at cycle 0, resp_valid at cycle 2+L.
  - The next request can be accepted at cycle 3+L.
- Arbitration fairness: with both requesters continuously valid, grants strictly alternate.

Decomposition:
- The shared package jsilicon_pkg holds:
  - the state enum;
  - the opcode width constant (3) and operand width constant (8);
  - the result width (16);
  - REQ_W (1).
- One natural sub-module is rr_arbiter2: two valid inputs, a last_grant register with update-on-accept, and outputs grant and grant_valid.

Test Plan:
- Reset, then req0 only (a=0x03, b=0x04, op=ADD, tx_enable=0, ALU_LAT=1) -> req0_ready at cycle 0, alu_start at cycle 1, resp_valid at cycle 3 with resp_id=0 and resp_result=0x0007; uart_start is never asserted.
- Both requesters held valid for 4 operations -> grant order 0,1,0,1; resp_id sequence matches.
- tx_enable=1, ALU returns 0x1234, UART model holds busy for 10 cycles -> uart_start pulses carrying 0x12, then 0x34; the second pulse comes only after busy falls; resp_valid comes after the second byte completes.
- uart_busy already high at TX_HI entry -> uart_start is withheld until busy drops; no lost or duplicate byte.
- reset asserted in TX_LO_WAIT -> next cycle state is IDLE, all outputs are 0, no resp_valid, and requester 0 wins the next tie.
- ALU_LAT=3 -> resp_result is captured exactly 3 cycles after alu_start; a value presented earlier on alu_result is ignored.

Source files
------------

// File: rtl/jsilicon_pkg.sv
// jsilicon_pkg: shared widths and scheduler state encoding
package jsilicon_pkg;
    localparam int OP_W   = 3;
    localparam int OPND_W = 8;
    localparam int RES_W  = 16;
    localparam int REQ_W  = 1;
    typedef enum logic [2:0] {
        IDLE, ISSUE, WAIT_ALU, TX_HI, TX_HI_WAIT, TX_LO, TX_LO_WAIT, DONE
    } state_t;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter; last_grant only moves on an accepted grant
module rr_arbiter2
    import jsilicon_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       valid,
    input  logic             accept,
    output logic [REQ_W-1:0] grant,
    output logic             grant_valid
);
    logic [REQ_W-1:0] last_grant;
    assign grant       = &valid ? ~last_grant : valid[1];
    assign grant_valid = |valid;
    // resets to 1 so requester 0 wins the first tie
    always_ff @(posedge clock) begin
        if (reset)
            last_grant <= 1'b1;
        else if (accept)
            last_grant <= grant;
    end
endmodule

// File: rtl/alu_uart_scheduler.sv
// alu_uart_scheduler: arbitrates two requesters onto one ALU and optionally streams
// the 16-bit result over UART (high byte first) before answering the winner
module alu_uart_scheduler
    import jsilicon_pkg::*;
#(
    parameter int ALU_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OPND_W-1:0] req0_a,
    input  logic [OPND_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OPND_W-1:0] req1_a,
    input  logic [OPND_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,
    input  logic              tx_enable,
    output logic [OPND_W-1:0] alu_a,
    output logic [OPND_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    output logic              alu_start,
    input  logic [RES_W-1:0]  alu_result,
    output logic [7:0]        uart_data,
    output logic              uart_start,
    input  logic              uart_busy,
    output logic              resp_valid,
    output logic [REQ_W-1:0]  resp_id,
    output logic [RES_W-1:0]  resp_result,
    output logic              busy
);
    state_t state, next;
    logic [2:0] cnt;
    logic tx_lat, first, grant_valid, accept;
    logic [REQ_W-1:0] grant;

    rr_arbiter2 arb (
        .clock(clock),
        .reset(reset),
        .valid({req1_valid, req0_valid}),
        .accept(accept),
        .grant(grant),
        .grant_valid(grant_valid)
    );

    assign accept     = state == IDLE && grant_valid;
    assign req0_ready = accept && grant == 1'b0;
    assign req1_ready = accept && grant == 1'b1;
    assign resp_valid = state == DONE;
    assign busy       = state != IDLE;

    always_ff @(posedge clock) begin
        if (reset)
            state <= IDLE;
        else
            state <= next;
    end

    always_comb begin
        next       = state;
        alu_start  = 1'b0;
        uart_start = 1'b0;
        uart_data  = state == TX_HI ? resp_result[15:8] : state == TX_LO ? resp_result[7:0] : 8'h00;
        case (state)
            IDLE:       next = accept ? ISSUE : IDLE;
            ISSUE: begin
                alu_start = 1'b1;
                next      = WAIT_ALU;
            end
            WAIT_ALU:   next = cnt != 3'd0 ? WAIT_ALU : tx_lat ? TX_HI : DONE;
            TX_HI, TX_LO: begin
                uart_start = !uart_busy;
                next       = uart_busy ? state : state == TX_HI ? TX_HI_WAIT : TX_LO_WAIT;
            end
            // the UART raises busy one cycle late, so the first wait cycle is blind
            TX_HI_WAIT: next = !first && !uart_busy ? TX_LO : TX_HI_WAIT;
            TX_LO_WAIT: next = !first && !uart_busy ? DONE : TX_LO_WAIT;
            DONE:       next = IDLE;
            default:    next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= '0;
            resp_id     <= '0;
            resp_result <= '0;
            tx_lat      <= 1'b0;
            cnt         <= 3'd0;
            first       <= 1'b0;
        end else begin
            if (accept) begin
                alu_a   <= grant ? req1_a : req0_a;
                alu_b   <= grant ? req1_b : req0_b;
                alu_op  <= grant ? req1_op : req0_op;
                resp_id <= grant;
                tx_lat  <= tx_enable;
            end
            if (state == ISSUE)
                cnt <= 3'(ALU_LAT - 1);
            if (state == WAIT_ALU && cnt == 3'd0)
                resp_result <= alu_result;
            else if (state == WAIT_ALU)
                cnt <= cnt - 3'd1;
            first <= uart_start;
        end
    end
endmodule
